uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter that sits on the CPU data bus downstream of the MEM stage, alongside data memory. It consumes the store/load transactions the pipeline issues (address, read/write strobes, write data), buffers outgoing bytes in a small FIFO, and serialises them as 8N1 frames on a single `tx` line. It also exposes a status register and a level interrupt for polling or interrupt-driven software.

---
 rtl/uart_tx_periph.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers on the CPU data bus,
// small TX FIFO, serial shifter and a level interrupt for an idle, drained transmitter.
module uart_tx_periph #(
   parameter int unsigned CLK_DIV    = 434,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0018
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        Mem_rd,
   input  logic        Mem_wr,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   output logic        tx,
   output logic        irq
);

   localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              irq_q, irq_d;
   logic              irq_en_q, irq_en_d;
   logic              ovf_q, ovf_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        mem [FIFO_DEPTH];

   logic        hit_data, hit_stat;
   logic        push_req, push, pop, stat_wr;
   logic        full, empty, busy, baud_end;
   logic [31:0] status;
   logic        unused_wdata;

   assign hit_data = (addr == BASE_ADDR);
   assign hit_stat = (addr == STAT_ADDR);
   assign push_req = Mem_wr & hit_data;
   assign stat_wr  = Mem_wr & hit_stat;
   assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty    = (cnt_q == '0);
   assign busy     = (state_q != S_IDLE);
   assign baud_end = (baud_q == BAUD_W'(CLK_DIV - 1));
   // A push into a full FIFO still lands when the shifter drains the head this cycle.
   assign push     = push_req & (~full | pop);

   assign status    = {27'd0, irq_en_q, ovf_q, busy, empty, full};
   assign Read_data = (Mem_rd && hit_stat) ? status : 32'd0;
   assign unused_wdata = ^Write_data[31:8];

   assign tx  = tx_q;
   assign irq = irq_q;

   // Serialiser next-state: start bit, 8 data bits LSB first, stop bit.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr_q];
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping, control/status registers and interrupt.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      irq_en_d = irq_en_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      if (stat_wr) begin
         irq_en_d = Write_data[4];
         if (Write_data[3]) ovf_d = 1'b0;
      end
      if (push_req && full && !pop) ovf_d = 1'b1;
      irq_d = irq_en_q & empty & ~busy;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         irq_q    <= 1'b0;
         irq_en_q <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         irq_q    <= irq_d;
         irq_en_q <= irq_en_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= Write_data[7:0];
   end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with CLK_DIV=4, FIFO_DEPTH=4: frame shape,
// back-to-back frames, overflow, interrupt, async reset and address decode.
module tb_uart_tx_periph;

   localparam logic [31:0] TXD  = 32'h4000_0018;
   localparam logic [31:0] STAT = 32'h4000_001C;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        Mem_rd, Mem_wr;
   logic [31:0] Write_data;
   logic [31:0] Read_data;
   logic        tx, irq;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  q_bytes [8];
   logic [31:0] st;

   uart_tx_periph #(
      .CLK_DIV   (4),
      .FIFO_DEPTH(4),
      .BASE_ADDR (TXD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .Mem_rd    (Mem_rd),
      .Mem_wr    (Mem_wr),
      .Write_data(Write_data),
      .Read_data (Read_data),
      .tx        (tx),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr       = a;
      Write_data = d;
      Mem_wr     = 1'b1;
      tick();
      Mem_wr     = 1'b0;
      addr       = '0;
      Write_data = '0;
   endtask

   task automatic check_status(input string tag, input logic [31:0] exp);
      addr   = STAT;
      Mem_rd = 1'b1;
      #1;
      st     = Read_data;
      Mem_rd = 1'b0;
      addr   = '0;
      check(tag, st, exp);
   endtask

   // Expected line level k cycles after the first start bit of a contiguous run of frames.
   function automatic logic exp_bit(input int k);
      int f, b;
      f = k / 40;
      b = (k % 40) / 4;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return q_bytes[f][b-1];
   endfunction

   task automatic check_stream(input string tag, input int k0, input int k1);
      for (int k = k0; k < k1; k++) begin
         check(tag, {31'd0, tx}, {31'd0, exp_bit(k)});
         tick();
      end
   endtask

   initial begin
      reset      = 1'b0;
      addr       = '0;
      Mem_rd     = 1'b0;
      Mem_wr     = 1'b0;
      Write_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rdata", Read_data, 32'd0);
      reset = 1'b1;
      tick();
      check_status("rst_status", 32'h2);

      // Single frame 0xA5 from idle
      q_bytes[0] = 8'hA5;
      wr(TXD, 32'hA5);
      check("a5_pre_tx", {31'd0, tx}, 32'd1);
      check_status("a5_queued", 32'h0);
      tick();
      check_stream("a5_line", 0, 39);
      check_status("a5_stop_status", 32'h6);
      check_stream("a5_line", 39, 40);
      check_status("a5_done_status", 32'h2);

      // Two back-to-back frames
      q_bytes[0] = 8'h01;
      q_bytes[1] = 8'h80;
      wr(TXD, 32'h01);
      wr(TXD, 32'h80);
      check_status("b2b_first", 32'h4);
      check_stream("b2b_line", 0, 39);
      check_status("b2b_pre_pop", 32'h4);
      check_stream("b2b_line", 39, 40);
      check_status("b2b_post_pop", 32'h6);
      check_stream("b2b_line", 40, 80);
      check_status("b2b_done", 32'h2);

      // Overflow: six writes, five bytes survive
      q_bytes[0] = 8'h11;
      q_bytes[1] = 8'h22;
      q_bytes[2] = 8'h33;
      q_bytes[3] = 8'h44;
      q_bytes[4] = 8'h55;
      for (int i = 0; i < 6; i++) wr(TXD, 32'h11 * (i + 1));
      check_status("ovf_full", 32'hD);
      check_stream("ovf_line", 4, 200);
      check_status("ovf_sticky", 32'hA);
      wr(STAT, 32'h8);
      check_status("ovf_clear", 32'h2);

      // Interrupt enable and busy masking
      q_bytes[0] = 8'h3C;
      wr(STAT, 32'h10);
      check("irq_lag", {31'd0, irq}, 32'd0);
      tick();
      check("irq_on", {31'd0, irq}, 32'd1);
      wr(TXD, 32'h3C);
      check("irq_pre_busy", {31'd0, irq}, 32'd1);
      tick();
      check("irq_busy", {31'd0, irq}, 32'd0);
      check_stream("irq_line", 0, 40);
      check("irq_just_idle", {31'd0, irq}, 32'd0);
      tick();
      check("irq_back", {31'd0, irq}, 32'd1);
      check_status("irq_status", 32'h12);

      // Asynchronous reset mid-DATA with bytes queued
      for (int i = 0; i < 3; i++) wr(TXD, 32'h00);
      repeat (5) tick();
      check("rstmid_data_low", {31'd0, tx}, 32'd0);
      #3;
      reset = 1'b0;
      #1;
      check("rstmid_tx_async", {31'd0, tx}, 32'd1);
      check("rstmid_irq", {31'd0, irq}, 32'd0);
      check_status("rstmid_status", 32'h2);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 45; i++) begin
         tick();
         check("rstmid_quiet", {31'd0, tx}, 32'd1);
      end
      check_status("rstmid_after", 32'h2);

      // Simultaneous read and write of STATUS returns pre-write state
      addr       = STAT;
      Write_data = 32'h10;
      Mem_rd     = 1'b1;
      Mem_wr     = 1'b1;
      #1;
      check("rdwr_old", Read_data, 32'h2);
      tick();
      Mem_wr = 1'b0;
      #1;
      check("rdwr_new", Read_data, 32'h12);
      addr = TXD;
      #1;
      check("txdata_read", Read_data, 32'h0);
      addr = STAT + 32'd4;
      #1;
      check("miss_read", Read_data, 32'h0);
      Mem_rd = 1'b0;

      // Writes to non-matching addresses have no effect
      wr(STAT + 32'd4, 32'h55);
      wr(TXD + 32'd1, 32'h55);
      for (int i = 0; i < 3; i++) begin
         check("miss_tx", {31'd0, tx}, 32'd1);
         tick();
      end
      check_status("miss_status", 32'h12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
